velocity_cell_writer: RTL and testbench
=======================================

// Module: velocity_cell_writer
// PURPOSE
//   Write-side initiator for one velocity cell memory (single-port, 1-cycle read latency).
//   Accepts the updated {vz,vy,vx} records of one cell from motion update on a valid/ready stream.
//   Packs records into addresses 1..N, then writes particle count N to address 0.
//   Sits between the motion-update pipeline and the velocity_x_y_z cell RAM.
// PARAMETERS
//   DATA_WIDTH    96   record width, MSB-LSB {vz,vy,vx}, 32 bits each
//   PARTICLE_NUM  220  RAM depth in words; max records per cell = PARTICLE_NUM-1
//   ADDR_WIDTH    8    RAM address width
// PORTS
//   clk            in   1           single clock, all logic rising-edge
//   rst            in   1           synchronous, active-high reset
//   start          in   1           begin a cell write pass; honoured only in IDLE
//   cell_empty     in   1           sampled with start: cell has zero particles
//   in_valid       in   1           record valid
//   in_ready       out  1           writer accepts a record
//   in_data        in   DATA_WIDTH  velocity record {vz,vy,vx}
//   in_last        in   1           qualifies in_valid: last record of the cell
//   ram_address    out  ADDR_WIDTH  RAM address
//   ram_data       out  DATA_WIDTH  RAM write data
//   ram_wren       out  1           RAM write enable
//   ram_rden       out  1           RAM read enable, held 0
//   busy           out  1           pass in progress
//   done           out  1           one-cycle pulse, pass complete
//   particle_count out  ADDR_WIDTH  records written in the current/last pass
//   overflow       out  1           sticky until next start: records were dropped
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, wr_ptr=1. Reset mid-pass aborts at once; RAM content already written is left as is.
//   States: IDLE -> STREAM (start & !cell_empty) | WRITE_COUNT (start & cell_empty); STREAM -> WRITE_COUNT on last handshake;
//     WRITE_COUNT -> DONE; DONE -> IDLE.
//   start while not IDLE is ignored. start clears particle_count and overflow and sets wr_ptr=1.
//   in_ready = 1 only in STREAM, and 0 in the cycle after the last handshake.
//   Handshake = in_valid & in_ready. Only cycles with a handshake write.
//   All ram_* outputs are registered. A handshake in cycle t gives ram_wren=1, ram_address=wr_ptr and ram_data=in_data in cycle t+1.
//   After each write, wr_ptr increments and particle_count increments.
//   Bubbles (in_valid=0) give ram_wren=0. Addresses stay contiguous.
//   Overflow: a handshake with wr_ptr == PARTICLE_NUM is accepted and dropped.
//     No write, no count increment, overflow=1. in_ready stays 1 so the stream drains to in_last.
//   WRITE_COUNT: ram_address=0, ram_data={zeros,particle_count} (count in [ADDR_WIDTH-1:0]), ram_wren=1.
//   Last handshake at t: record write at t+1, count write at t+2, done=1 at t+3, busy=0 from t+3.
//   An overflowed last record still ends the pass.
//   Empty cell: start at t: count write (addr0=0) at t+1, done at t+2.
//   busy=1 from the cycle after start through the count-write cycle.
//   ram_rden=0 always. The writer never reads.
//   wr_ptr and count are ADDR_WIDTH wide. wr_ptr saturates at PARTICLE_NUM and never wraps.
// CONFIGURATION
//   VEL_WB_ZERO_FILL_EN defined: state ZERO_FILL is inserted between STREAM/empty-start and WRITE_COUNT.
//     It writes data 0 to addresses particle_count+1 .. PARTICLE_NUM-1, one per cycle, then the count write.
//     done is delayed by PARTICLE_NUM-1-particle_count cycles.
//   VEL_WB_ZERO_FILL_EN undefined: no fill. Stale entries above N remain in the RAM.
// TESTING
//   1 Reset: hold rst 2 cycles -> all outputs 0, in_ready=0. Then start with no stream -> ram_wren stays 0 until in_valid.
//   2 start; continuous records A,B,C, last on C -> writes (1,A),(2,B),(3,C), then (0,3).
//     done one cycle after the count write; particle_count=3.
//   3 Same as 2 with in_valid low 2 cycles between A and B -> no wren in bubbles, addresses 1,2,3, count=3.
//   4 start with cell_empty=1 at t -> single write (0,0) at t+1, done at t+2, particle_count=0.
//   5 PARTICLE_NUM=220, 221 records -> writes at addresses 1..219, 2 records dropped.
//     overflow=1, count write (0,219).
//   6 Reset after 2 records, then start, 1 record -> write (1,rec), then (0,1).
//     With VEL_WB_ZERO_FILL_EN and 3 records: zeros to 4..219, then (0,3).

Source files
------------

// File: rtl/velocity_cell_writer.sv
// ============================================================================
// velocity_cell_writer
// ----------------------------------------------------------------------------
// Write-side initiator for one velocity cell memory. This memory is a
// single-port RAM with a 1-cycle read latency. The block sits between the
// motion-update pipeline and the velocity_x_y_z cell RAM.
//
// One pass writes one cell:
//   - The updated {vz,vy,vx} records arrive on a valid/ready stream.
//   - They are packed into RAM addresses 1..N.
//   - The particle count N is then written to address 0.
//
// Optional build feature (macro VEL_WB_ZERO_FILL_EN):
//   When this macro is defined, the block writes zeros to the unused words
//   N+1..PARTICLE_NUM-1. It does this before the count write.
//   When the macro is undefined, stale words above N are left in the RAM.
//
// Ports
//   clk            in   1           single clock, rising edge
//   rst            in   1           synchronous, active-high reset
//   start          in   1           begin a cell pass (honoured only in IDLE)
//   cell_empty     in   1           sampled with start: cell has no particles
//   in_valid       in   1           record valid
//   in_ready       out  1           writer accepts a record
//   in_data        in   DATA_WIDTH  velocity record {vz,vy,vx}
//   in_last        in   1           last record of the cell (with in_valid)
//   ram_address    out  ADDR_WIDTH  RAM address (registered)
//   ram_data       out  DATA_WIDTH  RAM write data (registered)
//   ram_wren       out  1           RAM write enable (registered)
//   ram_rden       out  1           RAM read enable, always 0
//   busy           out  1           pass in progress
//   done           out  1           one-cycle pulse, pass complete
//   particle_count out  ADDR_WIDTH  records written in current/last pass
//   overflow       out  1           sticky until next start: records dropped
//   dbg_state      out  3           current FSM state encoding
//
// Stream contract:
//   A record transfers in every cycle where in_valid & in_ready is 1.
//   in_ready never depends on in_valid. A producer may hold in_valid high
//   with stable in_data and in_last until it sees the transfer.
//   in_last is only meaningful in a transfer cycle.
// ============================================================================
module velocity_cell_writer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cell_empty,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  ram_rden,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  overflow,
    output logic [2:0]            dbg_state
);

    // Each state names what is visible on the RAM port during that cycle.
    //
    // STREAM  : records are accepted. Including the drain cycle, the RAM port
    //           shows their writes one cycle after the transfer.
    // ZERO_FILL: a zero write to an unused word is on the RAM port.
    // WRITE_COUNT: the count write to address 0 is on the RAM port.
    // DONE    : the done pulse.
    //
    // All RAM-port values are issued one cycle ahead and are held in
    // registers.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_STREAM      = 3'd1,
        S_ZERO_FILL   = 3'd2,
        S_WRITE_COUNT = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] L_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] L_PTR_MAX = ADDR_WIDTH'(PARTICLE_NUM);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic                    r_overflow;

    // r_drain marks the cycle right after the last transfer.
    // In that cycle in_ready is low and the record write is on the RAM port.
    logic                    r_drain;
    logic                    r_ram_wren;
    logic [ADDR_WIDTH-1:0]   r_ram_address;
    logic [DATA_WIDTH-1:0]   r_ram_data;

    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   w_count_nxt;
    logic                    w_overflow_nxt;
    logic                    w_drain_nxt;
    logic                    w_wren_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_data_nxt;

    logic                    w_in_ready;
    logic                    w_handshake;
    logic [DATA_WIDTH-1:0]   w_count_word;

    assign w_in_ready   = (r_state == S_STREAM) && !r_drain;
    assign w_handshake  = in_valid && w_in_ready;
    assign w_count_word = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, r_count};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next RAM-port / datapath values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_wr_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_drain_nxt    = r_drain;
        w_wren_nxt     = 1'b0;
        w_addr_nxt     = r_ram_address;
        w_data_nxt     = r_ram_data;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                    w_ptr_nxt      = L_PTR_ONE;
                    w_drain_nxt    = 1'b0;
                    if (!cell_empty) begin
                        w_state_nxt = S_STREAM;
                    end else begin
`ifdef VEL_WB_ZERO_FILL_EN
                        // An empty cell fills words 1..PARTICLE_NUM-1 first.
                        if (L_PTR_ONE < L_PTR_MAX) begin
                            w_wren_nxt  = 1'b1;
                            w_addr_nxt  = L_PTR_ONE;
                            w_data_nxt  = '0;
                            w_ptr_nxt   = L_PTR_ONE + L_PTR_ONE;
                            w_state_nxt = S_ZERO_FILL;
                        end else begin
                            w_wren_nxt  = 1'b1;
                            w_addr_nxt  = '0;
                            w_data_nxt  = '0;
                            w_state_nxt = S_WRITE_COUNT;
                        end
`else
                        // The count is zero, so the count write goes out
                        // right away.
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = '0;
                        w_data_nxt  = '0;
                        w_state_nxt = S_WRITE_COUNT;
`endif
                    end
                end
            end

            S_STREAM: begin
                if (r_drain) begin
                    // The last record's write is on the port this cycle.
                    // Issue the next write behind it.
                    w_drain_nxt = 1'b0;
`ifdef VEL_WB_ZERO_FILL_EN
                    // r_wr_ptr is count+1 here, which is the first unused
                    // word.
                    if (r_wr_ptr < L_PTR_MAX) begin
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = r_wr_ptr;
                        w_data_nxt  = '0;
                        w_ptr_nxt   = r_wr_ptr + L_PTR_ONE;
                        w_state_nxt = S_ZERO_FILL;
                    end else begin
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = '0;
                        w_data_nxt  = w_count_word;
                        w_state_nxt = S_WRITE_COUNT;
                    end
`else
                    w_wren_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = w_count_word;
                    w_state_nxt = S_WRITE_COUNT;
`endif
                end else if (w_handshake) begin
                    // When the pointer has reached PARTICLE_NUM, the RAM is
                    // full. The record is still accepted, so the producer can
                    // drain to in_last, but it is dropped.
                    if (r_wr_ptr != L_PTR_MAX) begin
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = r_wr_ptr;
                        w_data_nxt  = in_data;
                        w_ptr_nxt   = r_wr_ptr + L_PTR_ONE;
                        w_count_nxt = r_count + L_PTR_ONE;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (in_last) begin
                        w_drain_nxt = 1'b1;
                    end
                end
            end

`ifdef VEL_WB_ZERO_FILL_EN
            S_ZERO_FILL: begin
                if (r_wr_ptr < L_PTR_MAX) begin
                    w_wren_nxt = 1'b1;
                    w_addr_nxt = r_wr_ptr;
                    w_data_nxt = '0;
                    w_ptr_nxt  = r_wr_ptr + L_PTR_ONE;
                end else begin
                    w_wren_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = w_count_word;
                    w_state_nxt = S_WRITE_COUNT;
                end
            end
`endif

            S_WRITE_COUNT: begin
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and RAM-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= L_PTR_ONE;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_drain       <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else begin
            r_wr_ptr      <= w_ptr_nxt;
            r_count       <= w_count_nxt;
            r_overflow    <= w_overflow_nxt;
            r_drain       <= w_drain_nxt;
            r_ram_wren    <= w_wren_nxt;
            r_ram_address <= w_addr_nxt;
            r_ram_data    <= w_data_nxt;
        end
    end

    assign in_ready       = w_in_ready;
    assign ram_address    = r_ram_address;
    assign ram_data       = r_ram_data;
    assign ram_wren       = r_ram_wren;
    assign ram_rden       = 1'b0;
    assign busy           = (r_state == S_STREAM) || (r_state == S_ZERO_FILL) ||
                            (r_state == S_WRITE_COUNT);
    assign done           = (r_state == S_DONE);
    assign particle_count = r_count;
    assign overflow       = r_overflow;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_velocity_cell_writer.sv
// ============================================================================
// tb_velocity_cell_writer
// ----------------------------------------------------------------------------
// Directed bench for velocity_cell_writer.
//
// Structure:
//   - A cycle table covers the short passes: the contiguous stream, the
//     stream with bubbles, and the empty cell.
//   - Hand-written sequences cover the rest: reset and abort, overflow, and
//     the sticky overflow bit.
//   - In these sequences, RAM writes are checked against an expected queue.
// ============================================================================
module tb_velocity_cell_writer;
    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cell_empty;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic          ram_rden;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic          overflow;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    velocity_cell_writer #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cell_empty    (cell_empty),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .ram_rden      (ram_rden),
        .busy          (busy),
        .done          (done),
        .particle_count(particle_count),
        .overflow      (overflow),
        .dbg_state     (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] rec(input int i);
        return {32'(i * 3 + 1), 32'(i * 5 + 2), 32'(i + 4096)};
    endfunction

    task automatic idle_inputs();
        start      = 1'b0;
        cell_empty = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"}, DW'(in_ready), '0);
        chk({tag, "_wren"},  DW'(ram_wren), '0);
        chk({tag, "_addr"},  DW'(ram_address), '0);
        chk({tag, "_data"},  ram_data, '0);
        chk({tag, "_busy"},  DW'(busy), '0);
        chk({tag, "_done"},  DW'(done), '0);
        chk({tag, "_count"}, DW'(particle_count), '0);
        chk({tag, "_ovf"},   DW'(overflow), '0);
        chk({tag, "_rden"},  DW'(ram_rden), '0);
    endtask

    // ---------------- driver + scoreboard for one streamed pass ----------------
    // Call at a negedge with the DUT idle. The task returns at a negedge, with
    // the DUT back in IDLE.
    task automatic run_pass(input string tag, input int n);
        int nw;
        int idx;
        logic done_seen;
        logic [AW+DW-1:0] e;
        nw = (n < PN) ? n : PN - 1;
        exp_q.delete();
        for (int i = 1; i <= nw; i++) exp_q.push_back({AW'(i), rec(i)});
`ifdef VEL_WB_ZERO_FILL_EN
        for (int a = nw + 1; a <= PN - 1; a++) exp_q.push_back({AW'(a), DW'(0)});
`endif
        exp_q.push_back({AW'(0), DW'(nw)});

        start = 1'b1;
        cell_empty = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 1;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
            chk({tag, "_rden"}, DW'(ram_rden), '0);
            if (ram_wren) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s_extra_write: got addr %0d want no write", tag, ram_address);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_addr"}, DW'(ram_address), DW'(e[AW+DW-1:DW]));
                    chk({tag, "_data"}, ram_data, e[DW-1:0]);
                end
            end
            if (done) done_seen = 1'b1;
            if (idx <= n) begin
                in_valid = 1'b1;
                in_data  = rec(idx);
                in_last  = (idx == n);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_done_seen"}, DW'(done_seen), DW'(1));
        chk({tag, "_q_left"}, DW'(exp_q.size()), '0);
        chk({tag, "_count"}, DW'(particle_count), DW'(nw));
        chk({tag, "_ovf"}, DW'(overflow), DW'(n > PN - 1));
        chk({tag, "_busy_end"}, DW'(busy), '0);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic          start;
        logic          empty;
        logic          valid;
        logic          last;
        int            dsel;
        logic          e_ready;
        logic          e_wren;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_busy;
        logic          e_done;
        int            e_cnt;  // -1: not checked in this row
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DW-1:0] pick(input int dsel);
        return (dsel == 0) ? DW'(0) : rec(100 + dsel);
    endfunction

    function automatic vec_t mk(input logic s, input logic em, input logic v, input logic l,
                                input int d, input logic rdy, input logic we, input int a,
                                input logic [DW-1:0] dat, input logic b, input logic dn,
                                input int c);
        vec_t r;
        r.start = s;  r.empty = em; r.valid = v;    r.last = l;   r.dsel = d;
        r.e_ready = rdy; r.e_wren = we; r.e_addr = AW'(a); r.e_data = dat;
        r.e_busy = b; r.e_done = dn; r.e_cnt = c;
        return r;
    endfunction

    task automatic run_table();
        vec_t v;
        logic [DW-1:0] ra, rb, rc;
        ra = pick(1);
        rb = pick(2);
        rc = pick(3);
        // contiguous A,B,C. The start during STREAM must be ignored.
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,'0,0,0,-1));
        tbl.push_back(mk(0,0,1,0,1, 1,0,0,'0,1,0,-1));
        tbl.push_back(mk(1,0,1,0,2, 1,1,1,ra,1,0,-1));
        tbl.push_back(mk(0,0,1,1,3, 1,1,2,rb,1,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,3,rc,1,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,DW'(3),1,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,1,3));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,0,3));
        // A, two bubbles, B, C
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,'0,0,0,-1));
        tbl.push_back(mk(0,0,1,0,1, 1,0,0,'0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,ra,1,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,'0,1,0,1));
        tbl.push_back(mk(0,0,1,0,2, 1,0,0,'0,1,0,1));
        tbl.push_back(mk(0,0,1,1,3, 1,1,2,rb,1,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,3,rc,1,0,3));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,DW'(3),1,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,1,3));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,0,-1));
        // empty cell. The start in the DONE cycle must be ignored.
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,'0,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,DW'(0),1,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,'0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,'0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            chk($sformatf("tbl%0d_ready", i), DW'(in_ready), DW'(v.e_ready));
            chk($sformatf("tbl%0d_wren", i),  DW'(ram_wren), DW'(v.e_wren));
            chk($sformatf("tbl%0d_busy", i),  DW'(busy), DW'(v.e_busy));
            chk($sformatf("tbl%0d_done", i),  DW'(done), DW'(v.e_done));
            chk($sformatf("tbl%0d_rden", i),  DW'(ram_rden), '0);
            if (v.e_wren) begin
                chk($sformatf("tbl%0d_addr", i), DW'(ram_address), DW'(v.e_addr));
                chk($sformatf("tbl%0d_data", i), ram_data, v.e_data);
            end
            if (v.e_cnt >= 0) chk($sformatf("tbl%0d_count", i), DW'(particle_count), DW'(v.e_cnt));
            start      = v.start;
            cell_empty = v.empty;
            in_valid   = v.valid;
            in_last    = v.last;
            in_data    = pick(v.dsel);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic done_seen;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");

        // Start with no stream: nothing is written while in_valid stays low.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nostream%0d_wren", i), DW'(ram_wren), '0);
            chk($sformatf("nostream%0d_ready", i), DW'(in_ready), DW'(1));
            chk($sformatf("nostream%0d_busy", i), DW'(busy), DW'(1));
            @(negedge clk);
        end
        // Two records, then a reset aborts the pass.
        in_valid = 1'b1;
        in_data  = rec(1);
        @(negedge clk);
        in_data  = rec(2);
        chk("abort_w1_wren", DW'(ram_wren), DW'(1));
        chk("abort_w1_addr", DW'(ram_address), DW'(1));
        chk("abort_w1_data", ram_data, rec(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_w2_addr", DW'(ram_address), DW'(2));
        chk("abort_w2_data", ram_data, rec(2));
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort_rst");
        rst = 1'b0;
        @(negedge clk);

        run_pass("one_rec", 1);

`ifdef VEL_WB_ZERO_FILL_EN
        run_pass("fill3", 3);
`else
        run_table();
`endif

        run_pass("ovf221", 221);

        // overflow stays set in IDLE until the next start clears it
        repeat (2) @(negedge clk);
        chk("ovf_sticky", DW'(overflow), DW'(1));
        chk("ovf_sticky_count", DW'(particle_count), DW'(PN - 1));
        start = 1'b1;
        cell_empty = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("ovf_cleared", DW'(overflow), '0);
        chk("count_cleared", DW'(particle_count), '0);
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            if (done) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("empty_done_seen", DW'(done_seen), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
